sram_ctrl_param: RTL

Parametrised asynchronous-SRAM controller for the memory stage. It accepts full-width read and write requests from the MEM stage over a hold-until-ready handshake. Each request is split into BEATS = DATA_W/DQ_W sequential half-word (by default) accesses to an external SRAM through a tri-state DQ bus. Wait states are programmable per beat, write strobes carry setup and hold margins, and `read_data` is committed atomically.

---
 rtl/sram_ctrl_param.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sram_ctrl_param.sv
// Asynchronous-SRAM controller: splits a DATA_W request into DATA_W/DQ_W beats with programmable wait states.
// SRAM strobes, address and DQ drive are registered; read_data is committed atomically on entry to DONE.
module sram_ctrl_param #(
  parameter int DATA_W      = 32,
  parameter int DQ_W        = 16,
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_wr_en,
  input  logic                   mem_rd_en,
  input  logic [31:0]            address,
  input  logic [DATA_W-1:0]      write_data,
  output logic [DATA_W-1:0]      read_data,
  output logic                   ready,
  output logic                   busy,
  inout  wire  [DQ_W-1:0]        SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N
);

  localparam int BEATS  = DATA_W / DQ_W;
  localparam int KW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WR_LEN = WAIT_CYCLES + 2;
  localparam int RD_LEN = WAIT_CYCLES + 1;
  localparam int CW     = $clog2(WR_LEN + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   op_wr, op_wr_nxt;
  logic [SRAM_ADDR_W-1:0] base, base_nxt;
  logic [DATA_W-1:0]      wdata, wdata_nxt;
  logic [KW-1:0]          k, k_nxt;
  logic [CW-1:0]          cyc, cyc_nxt;
  logic [DATA_W-1:0]      shadow, shadow_nxt;
  logic [DATA_W-1:0]      rdata_q, rdata_nxt;
  logic                   beat_last;

  logic [SRAM_ADDR_W-1:0] addr_q, addr_nxt;
  logic                   we_n_q, we_n_nxt;
  logic                   oe_n_q, oe_n_nxt;
  logic                   dq_oe_q, dq_oe_nxt;
  logic [DQ_W-1:0]        dq_out_q, dq_out_nxt;
  logic                   in_acc;

  logic unused_addr_bits;
  assign unused_addr_bits = ^address[31:SRAM_ADDR_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_wr    <= 1'b0;
      base     <= '0;
      wdata    <= '0;
      k        <= '0;
      cyc      <= '0;
      shadow   <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
    end else begin
      state    <= state_nxt;
      op_wr    <= op_wr_nxt;
      base     <= base_nxt;
      wdata    <= wdata_nxt;
      k        <= k_nxt;
      cyc      <= cyc_nxt;
      shadow   <= shadow_nxt;
      rdata_q  <= rdata_nxt;
      addr_q   <= addr_nxt;
      we_n_q   <= we_n_nxt;
      oe_n_q   <= oe_n_nxt;
      dq_oe_q  <= dq_oe_nxt;
      dq_out_q <= dq_out_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    op_wr_nxt  = op_wr;
    base_nxt   = base;
    wdata_nxt  = wdata;
    k_nxt      = k;
    cyc_nxt    = cyc;
    shadow_nxt = shadow;
    rdata_nxt  = rdata_q;
    beat_last  = 1'b0;

    case (state)
      IDLE: begin
        if (mem_wr_en | mem_rd_en) begin
          state_nxt = ACCESS;
          op_wr_nxt = mem_wr_en;
          base_nxt  = address[SRAM_ADDR_W-1:0];
          wdata_nxt = write_data;
          k_nxt     = '0;
          cyc_nxt   = '0;
        end
      end
      ACCESS: begin
        beat_last = op_wr ? (cyc == CW'(WR_LEN - 1)) : (cyc == CW'(RD_LEN - 1));
        if (beat_last) begin
          if (!op_wr) shadow_nxt[int'(k)*DQ_W +: DQ_W] = SRAM_DQ;
          if (k == KW'(BEATS - 1)) begin
            state_nxt = DONE;
            // Include the beat sampled on this same edge in the committed word
            if (!op_wr) rdata_nxt = shadow_nxt;
          end else begin
            k_nxt   = k + KW'(1);
            cyc_nxt = '0;
          end
        end else begin
          cyc_nxt = cyc + CW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pin values are derived from the next state so they are glitch-free registers
  always_comb begin
    in_acc     = (state_nxt == ACCESS);
    we_n_nxt   = !(in_acc && op_wr_nxt && (cyc_nxt >= CW'(1)) && (cyc_nxt <= CW'(WAIT_CYCLES)));
    oe_n_nxt   = !(in_acc && !op_wr_nxt);
    dq_oe_nxt  = in_acc && op_wr_nxt;
    addr_nxt   = in_acc ? (base_nxt + SRAM_ADDR_W'(k_nxt)) : addr_q;
    dq_out_nxt = in_acc ? wdata_nxt[int'(k_nxt)*DQ_W +: DQ_W] : dq_out_q;
  end

  assign SRAM_DQ   = dq_oe_q ? dq_out_q : {DQ_W{1'bz}};
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign read_data = rdata_q;
  assign ready     = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
